virtio_mmio_multiq: RTL
=======================

VIRTIO_MMIO_MULTIQ -- requirements
Module: virtio_mmio_multiq

Interface
REQ-001 SHALL have parameter NUM_QUEUES, default 2: virtqueue count, 1..8; QW = max(1, clog2(NUM_QUEUES)).
REQ-002 SHALL have parameter QUEUE_NUM_MAX, default 8: value returned by QueueNumMax.
REQ-003 SHALL have parameter NOTIFY_DEPTH, default 4: notify FIFO depth, power of two, at least 2.
REQ-004 SHALL have parameter DEVICE_ID, default 2: value returned by DeviceID (2 = block).
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports core_ar{addr[31:0],valid,prot[2:0]} in, core_arready out  AXI4-Lite read address.
REQ-008 SHALL have ports core_r{data[31:0],resp[1:0],valid} out, core_rready in  AXI4-Lite read data.
REQ-009 SHALL have ports core_aw{addr[31:0],valid,prot[2:0]} in, core_awready out  AXI4-Lite write address.
REQ-010 SHALL have ports core_w{data[31:0],strb[3:0],valid} in, core_wready out  AXI4-Lite write data.
REQ-011 SHALL have ports core_b{resp[1:0],valid} out, core_bready in  AXI4-Lite write response.
REQ-012 SHALL have ports notify_valid out 1, notify_queue out QW, notify_ready in 1  notify stream to the device engine.
REQ-013 SHALL have ports queue_ready out NUM_QUEUES, queue_num out NUM_QUEUES*16, queue_desc/queue_driver/queue_device out NUM_QUEUES*32 each  per-queue config, queue i at slice i.
REQ-014 SHALL have ports irq_used_set in 1, irq_config_set in 1  single-cycle interrupt-raise pulses from the device engine.
REQ-015 SHALL have port virtio_interrupt out 1  high while InterruptStatus is non-zero.

Function
REQ-016 SHALL decode core_araddr[7:0] / core_awaddr[7:0] as virtio-mmio v2 offsets: 0x00 Magic 0x74726976 RO; 0x04 Version 2 RO; 0x08 DeviceID RO; 0x0C VendorID 0x554D4551 RO; 0x30 QueueSel RW; 0x34 QueueNumMax RO; 0x38 QueueNum RW; 0x44 QueueReady RW; 0x50 QueueNotify WO; 0x60 InterruptStatus RO; 0x64 InterruptACK WO; 0x70 Status RW; 0x80/0x90/0xA0 QueueDesc/Driver/DeviceLow RW.
REQ-017 SHALL read 0 and ignore writes at all other offsets, with OKAY (2'b00) response.
REQ-018 Read channel SHALL assert core_arready only while no read response is pending, and assert core_rvalid the cycle after the AR handshake, holding it and core_rdata stable until core_rready.
REQ-019 Write channel SHALL assert core_awready and core_wready together, for one cycle, only when core_awvalid and core_wvalid are both high and no write response is pending; the register update SHALL occur in that cycle.
REQ-020 core_bvalid SHALL rise the cycle after the write handshake and hold until core_bready; core_wstrb is ignored and only full-word writes are supported.
REQ-021 Queue-indexed registers SHALL address the queue given by QueueSel; if QueueSel >= NUM_QUEUES, reads return 0 (including QueueNumMax) and writes are ignored.
REQ-022 A QueueNum write with value 0 or value > QUEUE_NUM_MAX SHALL be ignored.
REQ-023 A QueueNotify write with wdata < NUM_QUEUES SHALL push wdata[QW-1:0] into the notify FIFO; an out-of-range value SHALL be dropped with OKAY response.
REQ-024 A QueueNotify write while the FIFO is full SHALL be dropped with core_bresp = SLVERR (2'b10); FIFO contents SHALL be unchanged.
REQ-025 The notify stream SHALL present the FIFO head; an entry pops on notify_valid & notify_ready; a push and a pop in the same cycle while full or empty SHALL both take effect, with no loss.
REQ-026 irq_used_set SHALL set InterruptStatus[0] and irq_config_set SHALL set [1]; an InterruptACK write clears the bits set in wdata[1:0]; a set and an ACK of the same bit in the same cycle SHALL leave the bit set.
REQ-027 A Status write of 0 SHALL, in the same update cycle, clear Status, QueueSel, every queue_ready / queue_num / address register, InterruptStatus, and flush the FIFO.

Reset
REQ-028 On rst SHALL clear all registers, empty the FIFO, and drive core_arready/core_awready/core_wready/core_rvalid/core_bvalid/notify_valid/virtio_interrupt = 0, core_rdata = 0, and core_rresp = core_bresp = 0.
REQ-029 rst mid-transaction SHALL abandon any pending response; no core_bvalid or core_rvalid SHALL follow for it.

Configuration
REQ-030 With VIRTIO_NOTIFY_FIFO_EN defined, the notify buffer SHALL be NOTIFY_DEPTH deep; undefined, it SHALL be a single-entry holding register with the same full/SLVERR semantics and the NOTIFY_DEPTH parameter ignored.

Structure
REQ-031 Package virtio_pkg SHALL hold register offset constants, the magic/version/vendor values, and the AXI response codes OKAY/SLVERR.
REQ-032 The notify buffer SHALL be sub-module virtio_notify_fifo (parameters WIDTH, DEPTH; valid/ready on both sides).

Verification
REQ-033 Read 0x00, 0x04, 0x08 -> 0x74726976, 2, 2, each with rvalid exactly one cycle after arready.
REQ-034 QueueSel=1; write QueueNum=8, QueueDescLow=0x80001000, QueueReady=1 -> queue_num[31:16]=8, queue_desc[63:32]=0x80001000, queue_ready=2'b10; QueueNum=9 write ignored.
REQ-035 With notify_ready=0, five QueueNotify=1 writes -> first four OKAY, fifth SLVERR; release ready -> four beats with notify_queue=1.
REQ-036 irq_used_set pulse in the same cycle as an InterruptACK=1 write -> InterruptStatus=1; a later ACK=1 -> 0 and virtio_interrupt falls.
REQ-037 Program both queues and push 2 notifies, then write Status=0 -> all queue outputs 0, notify_valid=0, virtio_interrupt=0.

Source files
------------

// File: rtl/virtio_pkg.sv
// virtio_pkg: virtio-mmio register offsets, identity constants and AXI response codes
package virtio_pkg;
  localparam logic [7:0] OFF_MAGIC = 8'h00;
  localparam logic [7:0] OFF_VERSION = 8'h04;
  localparam logic [7:0] OFF_DEVICE_ID = 8'h08;
  localparam logic [7:0] OFF_VENDOR_ID = 8'h0C;
  localparam logic [7:0] OFF_QUEUE_SEL = 8'h30;
  localparam logic [7:0] OFF_QUEUE_NUM_MAX = 8'h34;
  localparam logic [7:0] OFF_QUEUE_NUM = 8'h38;
  localparam logic [7:0] OFF_QUEUE_READY = 8'h44;
  localparam logic [7:0] OFF_QUEUE_NOTIFY = 8'h50;
  localparam logic [7:0] OFF_INT_STATUS = 8'h60;
  localparam logic [7:0] OFF_INT_ACK = 8'h64;
  localparam logic [7:0] OFF_STATUS = 8'h70;
  localparam logic [7:0] OFF_QUEUE_DESC = 8'h80;
  localparam logic [7:0] OFF_QUEUE_DRIVER = 8'h90;
  localparam logic [7:0] OFF_QUEUE_DEVICE = 8'hA0;
  localparam logic [31:0] MAGIC_VALUE = 32'h7472_6976;
  localparam logic [31:0] VERSION_VALUE = 32'd2;
  localparam logic [31:0] VENDOR_VALUE = 32'h554D_4551;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
endpackage

// File: rtl/virtio_notify_fifo.sv
// virtio_notify_fifo: valid/ready FIFO with flush; a full FIFO accepts a push when the head pops
module virtio_notify_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [2**PW];
  logic [WIDTH-1:0] mem_d [2**PW];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign out_valid = cnt_q != '0;
  assign out_data = mem_q[rp_q];
  assign in_ready = cnt_q != CW'(DEPTH) || out_ready;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = in_data;
    wp_d = flush ? '0 : push ? inc(wp_q) : wp_q;
    rp_d = flush ? '0 : pop ? inc(rp_q) : rp_q;
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/virtio_mmio_multiq.sv
// virtio_mmio_multiq: AXI4-Lite virtio-mmio v2 multi-queue register block; VIRTIO_NOTIFY_FIFO_EN selects a NOTIFY_DEPTH notify FIFO
module virtio_mmio_multiq
  import virtio_pkg::*;
#(
  parameter int NUM_QUEUES = 2,
  parameter int QUEUE_NUM_MAX = 8,
  parameter int NOTIFY_DEPTH = 4,
  parameter int DEVICE_ID = 2,
  localparam int QW = NUM_QUEUES > 1 ? $clog2(NUM_QUEUES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                core_araddr,
  input  logic                       core_arvalid,
  input  logic [2:0]                 core_arprot,
  output logic                       core_arready,
  output logic [31:0]                core_rdata,
  output logic [1:0]                 core_rresp,
  output logic                       core_rvalid,
  input  logic                       core_rready,
  input  logic [31:0]                core_awaddr,
  input  logic                       core_awvalid,
  input  logic [2:0]                 core_awprot,
  output logic                       core_awready,
  input  logic [31:0]                core_wdata,
  input  logic [3:0]                 core_wstrb,
  input  logic                       core_wvalid,
  output logic                       core_wready,
  output logic [1:0]                 core_bresp,
  output logic                       core_bvalid,
  input  logic                       core_bready,
  output logic                       notify_valid,
  output logic [QW-1:0]              notify_queue,
  input  logic                       notify_ready,
  output logic [NUM_QUEUES-1:0]      queue_ready,
  output logic [NUM_QUEUES*16-1:0]   queue_num,
  output logic [NUM_QUEUES*32-1:0]   queue_desc,
  output logic [NUM_QUEUES*32-1:0]   queue_driver,
  output logic [NUM_QUEUES*32-1:0]   queue_device,
  input  logic                       irq_used_set,
  input  logic                       irq_config_set,
  output logic                       virtio_interrupt
);
`ifdef VIRTIO_NOTIFY_FIFO_EN
  localparam int FD = NOTIFY_DEPTH;
`else
  localparam int FD = 1;
`endif
  if (NUM_QUEUES < 1 || NUM_QUEUES > 8 || NOTIFY_DEPTH < 2 || (NOTIFY_DEPTH & (NOTIFY_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("virtio_mmio_multiq: unsupported NUM_QUEUES or NOTIFY_DEPTH");
  end
  logic [31:0] sel_q, sel_d, rdata_q, rdata_d, rmux, wd;
  logic [7:0] status_q, status_d, ra, wa;
  logic [1:0] isr_q, isr_d, bresp_q, bresp_d;
  logic [NUM_QUEUES-1:0] rdy_q, rdy_d;
  logic [NUM_QUEUES*16-1:0] num_q, num_d;
  logic [NUM_QUEUES*32-1:0] desc_q, desc_d, drv_q, drv_d, dev_q, dev_d;
  logic rvalid_q, rvalid_d, bvalid_q, bvalid_d;
  logic rd, wr, sel_ok, dev_reset, push_valid, push_ready, unused_ok;
  logic [QW-1:0] q;
  assign unused_ok = ^{core_arprot, core_awprot, core_wstrb, core_araddr[31:8], core_awaddr[31:8]};
  assign ra = core_araddr[7:0];
  assign wa = core_awaddr[7:0];
  assign wd = core_wdata;
  assign core_arready = ~rvalid_q & ~rst;
  assign rd = core_arvalid & core_arready;
  assign wr = core_awvalid & core_wvalid & ~bvalid_q & ~rst;
  assign core_awready = wr;
  assign core_wready = wr;
  assign sel_ok = sel_q < 32'(NUM_QUEUES);
  assign q = sel_q[QW-1:0];
  assign dev_reset = wr && wa == OFF_STATUS && wd == '0;
  assign push_valid = wr && wa == OFF_QUEUE_NOTIFY && wd < 32'(NUM_QUEUES);
  assign core_rvalid = rvalid_q;
  assign core_rdata = rdata_q;
  assign core_rresp = OKAY;
  assign core_bvalid = bvalid_q;
  assign core_bresp = bresp_q;
  assign queue_ready = rdy_q;
  assign queue_num = num_q;
  assign queue_desc = desc_q;
  assign queue_driver = drv_q;
  assign queue_device = dev_q;
  assign virtio_interrupt = |isr_q;
  always_comb begin
    rmux = '0;
    case (ra)
      OFF_MAGIC: rmux = MAGIC_VALUE;
      OFF_VERSION: rmux = VERSION_VALUE;
      OFF_DEVICE_ID: rmux = 32'(DEVICE_ID);
      OFF_VENDOR_ID: rmux = VENDOR_VALUE;
      OFF_QUEUE_SEL: rmux = sel_q;
      OFF_QUEUE_NUM_MAX: rmux = sel_ok ? 32'(QUEUE_NUM_MAX) : '0;
      OFF_QUEUE_NUM: rmux = sel_ok ? {16'd0, num_q[q*16 +: 16]} : '0;
      OFF_QUEUE_READY: rmux = sel_ok ? {31'd0, rdy_q[q]} : '0;
      OFF_INT_STATUS: rmux = {30'd0, isr_q};
      OFF_STATUS: rmux = {24'd0, status_q};
      OFF_QUEUE_DESC: rmux = sel_ok ? desc_q[q*32 +: 32] : '0;
      OFF_QUEUE_DRIVER: rmux = sel_ok ? drv_q[q*32 +: 32] : '0;
      OFF_QUEUE_DEVICE: rmux = sel_ok ? dev_q[q*32 +: 32] : '0;
      default: rmux = '0;
    endcase
  end
  always_comb begin
    sel_d = sel_q;
    status_d = status_q;
    rdy_d = rdy_q;
    num_d = num_q;
    desc_d = desc_q;
    drv_d = drv_q;
    dev_d = dev_q;
    if (wr)
      case (wa)
        OFF_QUEUE_SEL: sel_d = wd;
        OFF_QUEUE_NUM: if (sel_ok && wd != '0 && wd <= 32'(QUEUE_NUM_MAX)) num_d[q*16 +: 16] = wd[15:0];
        OFF_QUEUE_READY: if (sel_ok) rdy_d[q] = wd[0];
        OFF_STATUS: status_d = wd[7:0];
        OFF_QUEUE_DESC: if (sel_ok) desc_d[q*32 +: 32] = wd;
        OFF_QUEUE_DRIVER: if (sel_ok) drv_d[q*32 +: 32] = wd;
        OFF_QUEUE_DEVICE: if (sel_ok) dev_d[q*32 +: 32] = wd;
        default: ;
      endcase
    if (dev_reset) begin
      sel_d = '0;
      status_d = '0;
      rdy_d = '0;
      num_d = '0;
      desc_d = '0;
      drv_d = '0;
      dev_d = '0;
    end
    // raise pulses are OR-ed in last so a same-cycle ACK or device reset never loses them
    isr_d = ((dev_reset ? 2'b00 : isr_q) & ~((wr && wa == OFF_INT_ACK) ? wd[1:0] : 2'b00)) | {irq_config_set, irq_used_set};
    rvalid_d = rd | (rvalid_q & ~core_rready);
    rdata_d = rd ? rmux : rdata_q;
    bvalid_d = wr | (bvalid_q & ~core_bready);
    bresp_d = wr ? ((push_valid && !push_ready) ? SLVERR : OKAY) : bresp_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
      status_q <= '0;
      isr_q <= '0;
      rdy_q <= '0;
      num_q <= '0;
      desc_q <= '0;
      drv_q <= '0;
      dev_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q <= OKAY;
    end else begin
      sel_q <= sel_d;
      status_q <= status_d;
      isr_q <= isr_d;
      rdy_q <= rdy_d;
      num_q <= num_d;
      desc_q <= desc_d;
      drv_q <= drv_d;
      dev_q <= dev_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
    end
  end
  virtio_notify_fifo #(.WIDTH(QW), .DEPTH(FD)) u_notify_fifo (
    .clk(clk),
    .rst(rst),
    .flush(dev_reset),
    .in_valid(push_valid),
    .in_data(wd[QW-1:0]),
    .in_ready(push_ready),
    .out_valid(notify_valid),
    .out_data(notify_queue),
    .out_ready(notify_ready)
  );
endmodule
